// File: rtl/egress_drain_counter.sv
// Drains the four egress FIFOs (fifo4..fifo7) round-robin onto one serial output,
// checks each word's destination field and keeps saturating per-FIFO word counters.
module egress_drain_counter #(
  parameter int unsigned TAMANO_DATOS = 12,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [3:0]              fifo_empty,
  input  logic [TAMANO_DATOS-1:0] data_in4,
  input  logic [TAMANO_DATOS-1:0] data_in5,
  input  logic [TAMANO_DATOS-1:0] data_in6,
  input  logic [TAMANO_DATOS-1:0] data_in7,
  input  logic                    sink_ready,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [3:0]              pop,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [CNT_W-1:0]        count_out,
  output logic                    count_valid,
  output logic                    err_dest,
  output logic [1:0]              state
);

  localparam int unsigned DestLsb = 8;

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StIdle   = 2'd1,
    StActive = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rr_q, rr_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [1:0]              s1_src_q, s1_src_d;
  logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q [4];
  logic [CNT_W-1:0]        cnt_d [4];
  logic [CNT_W-1:0]        count_out_q, count_out_d;
  logic                    count_valid_q, count_valid_d;

  logic                    found;
  logic [1:0]              grant_idx;
  logic [1:0]              cand;
  logic                    pop_en;
  logic [TAMANO_DATOS-1:0] data_sel;

  // First non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_q;
    cand      = rr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!found && !fifo_empty[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign pop_en = (state_q == StActive) && sink_ready && !init && found;
  assign pop    = pop_en ? 4'(4'b0001 << grant_idx) : 4'b0000;

  // FIFO read data is valid the cycle after its pop; s1_src_q marks which one.
  always_comb begin
    data_sel = data_in4;
    unique case (s1_src_q)
      2'd0: data_sel = data_in4;
      2'd1: data_sel = data_in5;
      2'd2: data_sel = data_in6;
      2'd3: data_sel = data_in7;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    s1_valid_d    = pop_en;
    s1_src_d      = pop_en ? grant_idx : s1_src_q;
    valid_out_d   = s1_valid_q;
    data_out_d    = s1_valid_q ? data_sel : data_out_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    count_out_d   = count_out_q;
    count_valid_d = req;

    unique case (state_q)
      StInit:   state_d = StIdle;
      StIdle:   if (!(&fifo_empty) && sink_ready) state_d = StActive;
      StActive: if ((&fifo_empty) || !sink_ready) state_d = StIdle;
      default:  state_d = StInit;
    endcase

    if (pop_en) rr_d = grant_idx + 2'd1;

    // Word lands on data_out this edge: check its destination and count it.
    if (s1_valid_q) begin
      if (data_sel[DestLsb +: 2] != s1_src_q) err_d = 1'b1;
      if (cnt_q[s1_src_q] != {CNT_W{1'b1}}) cnt_d[s1_src_q] = cnt_q[s1_src_q] + CNT_W'(1);
    end

    // Reads see pre-increment values since cnt_q is sampled.
    if (req) count_out_d = idx[2] ? cnt_q[idx[1:0]] : '0;

    if (init) begin
      state_d       = StInit;
      rr_d          = 2'd0;
      s1_valid_d    = 1'b0;
      valid_out_d   = 1'b0;
      data_out_d    = '0;
      err_d         = 1'b0;
      for (int k = 0; k < 4; k++) cnt_d[k] = '0;
      count_out_d   = '0;
      count_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StInit;
      rr_q          <= 2'd0;
      s1_valid_q    <= 1'b0;
      s1_src_q      <= 2'd0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      err_q         <= 1'b0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      s1_valid_q    <= s1_valid_d;
      s1_src_q      <= s1_src_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign err_dest    = err_q;
  assign state       = state_q;

endmodule
